// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: the pipeline latch observations and memory-ready
// inputs, plus the latch enables, bubble valids and next-PC select that the
// central sequencer drives back into the pipeline.
interface pipeline_hazard_ctrl_if #(
   parameter int STALL_CNT_W = 32
);
   logic                   DE_V;
   logic [31:0]            DE_IR;
   logic                   EXE_V;
   logic [31:0]            EXE_IR;
   logic [4:0]             EXE_DRID;
   logic                   EXE_BR_RESOLVED;
   logic                   EXE_BR_TAKEN;
   logic                   EXE_ECALL;
   logic                   IF_STALL;
   logic                   MEM_STALL;
   logic                   LD_PC;
   logic                   LD_DE;
   logic                   LD_AGEX;
   logic                   LD_MEM;
   logic                   LD_WB;
   logic                   DE_V_IN;
   logic                   EXE_V_IN;
   logic [1:0]             PC_SEL;
   logic                   TRAP_CS;
   logic [1:0]             CTRL_STATE;
   logic [STALL_CNT_W-1:0] STALL_CNT;

   // Pipeline side: presents latch contents, consumes the control outputs.
   modport master (
      output DE_V, DE_IR, EXE_V, EXE_IR, EXE_DRID, EXE_BR_RESOLVED,
             EXE_BR_TAKEN, EXE_ECALL, IF_STALL, MEM_STALL,
      input  LD_PC, LD_DE, LD_AGEX, LD_MEM, LD_WB, DE_V_IN, EXE_V_IN,
             PC_SEL, TRAP_CS, CTRL_STATE, STALL_CNT
   );

   // Sequencer side.
   modport slave (
      input  DE_V, DE_IR, EXE_V, EXE_IR, EXE_DRID, EXE_BR_RESOLVED,
             EXE_BR_TAKEN, EXE_ECALL, IF_STALL, MEM_STALL,
      output LD_PC, LD_DE, LD_AGEX, LD_MEM, LD_WB, DE_V_IN, EXE_V_IN,
             PC_SEL, TRAP_CS, CTRL_STATE, STALL_CNT
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use interlock,
// branch resolution wait, ECALL drain-and-redirect and data-memory freeze.
// All control outputs are combinational from the registered state and the
// current inputs; only the debug state and the stall counter are registered.
module pipeline_hazard_ctrl #(
   parameter int STALL_CNT_W = 32
) (
   input  logic                  CLK,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave hz_if
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_BR_WAIT = 2'd1,
      S_DRAIN   = 2'd2,
      S_TRAP    = 2'd3
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [1:0]             r_drain_cnt, w_drain_nxt;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic [6:0] w_de_op, w_exe_op;
   logic       w_is_cf, w_uses_rs2, w_load_use, w_ecall;
   logic       w_ld_pc, w_ld_de, w_ld_agex, w_ld_mem, w_ld_wb;
   logic       w_de_v_in, w_exe_v_in, w_trap_cs;
   logic [1:0] w_pc_sel;

   // Instruction fields this block does not decode.
   logic w_unused;
   assign w_unused = ^{hz_if.DE_IR[31:25], hz_if.DE_IR[14:7], hz_if.EXE_IR[31:7]};

   assign w_de_op  = hz_if.DE_IR[6:0];
   assign w_exe_op = hz_if.EXE_IR[6:0];

   // Conditional branch, JAL, JALR.
   assign w_is_cf = hz_if.DE_V &&
                    (w_de_op == 7'b1100011 || w_de_op == 7'b1101111 ||
                     w_de_op == 7'b1100111);

   // R-type (64/32-bit), store and branch read rs2; everything else ignores it.
   assign w_uses_rs2 = (w_de_op == 7'b0110011) || (w_de_op == 7'b0111011) ||
                       (w_de_op == 7'b0100011) || (w_de_op == 7'b1100011);

   assign w_load_use = hz_if.EXE_V && (w_exe_op == 7'b0000011) &&
                       (hz_if.EXE_DRID != 5'd0) && hz_if.DE_V &&
                       ((hz_if.EXE_DRID == hz_if.DE_IR[19:15]) ||
                        (w_uses_rs2 && hz_if.EXE_DRID == hz_if.DE_IR[24:20]));

   // ECALL is only taken from the states where EXE still holds live work.
   assign w_ecall = hz_if.EXE_V && hz_if.EXE_ECALL &&
                    (r_state == S_RUN || r_state == S_BR_WAIT);

   // State and drain counter registers.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state     <= S_RUN;
         r_drain_cnt <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   // Stall counter: any cycle that does not push a valid instruction into EXE.
   always_ff @(posedge CLK) begin
      if (reset)
         r_stall_cnt <= '0;
      else if (!w_ld_agex || !w_exe_v_in)
         r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
   end

   // Next-state logic; a memory freeze holds state and drain counter as-is.
   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain_cnt;
      if (!hz_if.MEM_STALL) begin
         if (w_ecall) begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = 2'd2;
         end else begin
            case (r_state)
               // A control-flow instruction still moves to EXE when fetch is
               // stalled (same outputs), so it must be tracked in BR_WAIT.
               S_RUN:     if (!w_load_use && w_is_cf) w_state_nxt = S_BR_WAIT;
               S_BR_WAIT: if (hz_if.EXE_BR_RESOLVED) w_state_nxt = S_RUN;
               S_DRAIN: begin
                  w_drain_nxt = r_drain_cnt - 2'd1;
                  if (r_drain_cnt == 2'd1) w_state_nxt = S_TRAP;
               end
               S_TRAP:    w_state_nxt = S_RUN;
               default:   w_state_nxt = S_RUN;
            endcase
         end
      end
   end

   // Output logic: latch enables, bubble valids, PC select and trap strobe.
   always_comb begin
      w_ld_pc    = 1'b0;
      w_ld_de    = 1'b0;
      w_ld_agex  = 1'b0;
      w_ld_mem   = 1'b0;
      w_ld_wb    = 1'b0;
      w_de_v_in  = 1'b0;
      w_exe_v_in = 1'b0;
      w_pc_sel   = 2'd0;
      w_trap_cs  = 1'b0;
      if (!reset && !hz_if.MEM_STALL) begin
         if (w_ecall) begin
            // Flush DE/EXE behind the ECALL while it drains toward WB.
            w_ld_de   = 1'b1;
            w_ld_agex = 1'b1;
            w_ld_mem  = 1'b1;
            w_ld_wb   = 1'b1;
         end else begin
            case (r_state)
               S_RUN: begin
                  w_ld_pc    = 1'b1;
                  w_ld_de    = 1'b1;
                  w_ld_agex  = 1'b1;
                  w_ld_mem   = 1'b1;
                  w_ld_wb    = 1'b1;
                  w_de_v_in  = 1'b1;
                  w_exe_v_in = hz_if.DE_V;
                  if (w_load_use) begin
                     w_ld_pc    = 1'b0;
                     w_ld_de    = 1'b0;
                     w_exe_v_in = 1'b0;
                  end else if (hz_if.IF_STALL || w_is_cf) begin
                     w_ld_pc   = 1'b0;
                     w_de_v_in = 1'b0;
                  end
               end
               S_BR_WAIT: begin
                  w_ld_de   = 1'b1;
                  w_ld_agex = 1'b1;
                  w_ld_mem  = 1'b1;
                  w_ld_wb   = 1'b1;
                  if (hz_if.EXE_BR_RESOLVED) begin
                     w_ld_pc  = 1'b1;
                     w_pc_sel = hz_if.EXE_BR_TAKEN ? 2'd1 : 2'd0;
                  end
               end
               S_DRAIN: begin
                  w_ld_de   = 1'b1;
                  w_ld_agex = 1'b1;
                  w_ld_mem  = 1'b1;
                  w_ld_wb   = 1'b1;
               end
               S_TRAP: begin
                  w_ld_pc   = 1'b1;
                  w_ld_de   = 1'b1;
                  w_ld_agex = 1'b1;
                  w_ld_mem  = 1'b1;
                  w_ld_wb   = 1'b1;
                  w_pc_sel  = 2'd2;
                  w_trap_cs = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign hz_if.LD_PC      = w_ld_pc;
   assign hz_if.LD_DE      = w_ld_de;
   assign hz_if.LD_AGEX    = w_ld_agex;
   assign hz_if.LD_MEM     = w_ld_mem;
   assign hz_if.LD_WB      = w_ld_wb;
   assign hz_if.DE_V_IN    = w_de_v_in;
   assign hz_if.EXE_V_IN   = w_exe_v_in;
   assign hz_if.PC_SEL     = w_pc_sel;
   assign hz_if.TRAP_CS    = w_trap_cs;
   assign hz_if.CTRL_STATE = reset ? 2'd0 : r_state;
   assign hz_if.STALL_CNT  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Inputs change just after the
// falling edge; combinational outputs are sampled 1 time unit later and
// registered outputs after the following rising edge. A 3-bit stall counter
// makes the wrap-around reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

   localparam int CW = 3;

   localparam logic [31:0] NOP       = 32'h0000_0013; // addi x0,x0,0
   localparam logic [31:0] LD_X5     = 32'h0000_B283; // ld  x5,0(x1)
   localparam logic [31:0] LD_X0     = 32'h0000_3003; // ld  x0,0(x0)
   localparam logic [31:0] ADD_RS1   = 32'h0072_8333; // add x6,x5,x7
   localparam logic [31:0] ADD_RS2   = 32'h0053_8333; // add x6,x7,x5
   localparam logic [31:0] ADDI_IMM5 = 32'h0050_8313; // addi x6,x1,5
   localparam logic [31:0] ADD_X0    = 32'h0070_0333; // add x6,x0,x7
   localparam logic [31:0] BEQ       = 32'h0020_8063; // beq x1,x2,0
   localparam logic [31:0] ECALL     = 32'h0000_0073;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;

   pipeline_hazard_ctrl_if #(.STALL_CNT_W(CW)) hz_if ();

   pipeline_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
      .CLK   (CLK),
      .reset (reset),
      .hz_if (hz_if)
   );

   logic [4:0] ld;
   assign ld = {hz_if.LD_PC, hz_if.LD_DE, hz_if.LD_AGEX, hz_if.LD_MEM, hz_if.LD_WB};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Steady flow: valid nop in DE and EXE, memories ready.
   task automatic idle();
      hz_if.DE_V            = 1'b1;
      hz_if.DE_IR           = NOP;
      hz_if.EXE_V           = 1'b1;
      hz_if.EXE_IR          = NOP;
      hz_if.EXE_DRID        = 5'd0;
      hz_if.EXE_BR_RESOLVED = 1'b0;
      hz_if.EXE_BR_TAKEN    = 1'b0;
      hz_if.EXE_ECALL       = 1'b0;
      hz_if.IF_STALL        = 1'b0;
      hz_if.MEM_STALL       = 1'b0;
   endtask

   task automatic next_cyc();
      @(negedge CLK);
      idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #1;
      chk("rst_ld", ld, 5'b00000);
      chk("rst_vin", {hz_if.DE_V_IN, hz_if.EXE_V_IN}, 2'b00);
      chk("rst_pcsel", hz_if.PC_SEL, 2'd0);
      chk("rst_trap", hz_if.TRAP_CS, 1'b0);
      chk("rst_state", hz_if.CTRL_STATE, 2'd0);
      @(negedge CLK);
      reset = 1'b0;
      #1;
      chk("rst_cnt", hz_if.STALL_CNT, 0);
      chk("run_ld", ld, 5'b11111);
      chk("run_vin", {hz_if.DE_V_IN, hz_if.EXE_V_IN}, 2'b11);

      // Load-use on rs1: one bubble.
      next_cyc();
      hz_if.EXE_IR = LD_X5; hz_if.EXE_DRID = 5'd5; hz_if.DE_IR = ADD_RS1;
      #1;
      chk("lu1_ld", ld, 5'b00111);
      chk("lu1_exevin", hz_if.EXE_V_IN, 1'b0);
      next_cyc();
      hz_if.EXE_IR = ADD_RS1; hz_if.EXE_DRID = 5'd6;
      #1;
      chk("lu1_after_ld", ld, 5'b11111);
      chk("lu1_after_exevin", hz_if.EXE_V_IN, 1'b1);
      chk("lu1_cnt", hz_if.STALL_CNT, 1);

      // Load-use through rs2 of an R-type.
      next_cyc();
      hz_if.EXE_IR = LD_X5; hz_if.EXE_DRID = 5'd5; hz_if.DE_IR = ADD_RS2;
      #1;
      chk("lu2_ld", ld, 5'b00111);
      // I-type whose immediate field aliases rs2 = x5: no dependency.
      next_cyc();
      chk("lu2_cnt", hz_if.STALL_CNT, 2);
      hz_if.EXE_IR = LD_X5; hz_if.EXE_DRID = 5'd5; hz_if.DE_IR = ADDI_IMM5;
      #1;
      chk("addi_ld", ld, 5'b11111);
      // Load into x0 never interlocks.
      next_cyc();
      hz_if.EXE_IR = LD_X0; hz_if.EXE_DRID = 5'd0; hz_if.DE_IR = ADD_X0;
      #1;
      chk("x0_ld", ld, 5'b11111);
      chk("x0_exevin", hz_if.EXE_V_IN, 1'b1);

      // Fetch stall: PC and DE valid held back, downstream flows.
      next_cyc();
      chk("x0_cnt", hz_if.STALL_CNT, 2);
      hz_if.IF_STALL = 1'b1;
      #1;
      chk("ifs_ld", ld, 5'b01111);
      chk("ifs_vin", {hz_if.DE_V_IN, hz_if.EXE_V_IN}, 2'b01);

      // beq not taken: dispatch, one BR_WAIT cycle resolving, back to RUN.
      next_cyc();
      chk("ifs_cnt", hz_if.STALL_CNT, 2);
      hz_if.DE_IR = BEQ;
      #1;
      chk("bnt_disp_ld", ld, 5'b01111);
      chk("bnt_disp_vin", {hz_if.DE_V_IN, hz_if.EXE_V_IN}, 2'b01);
      next_cyc();
      hz_if.DE_V = 1'b0; hz_if.EXE_IR = BEQ;
      hz_if.EXE_BR_RESOLVED = 1'b1; hz_if.EXE_BR_TAKEN = 1'b0;
      #1;
      chk("bnt_state", hz_if.CTRL_STATE, 2'd1);
      chk("bnt_ld", ld, 5'b11111);
      chk("bnt_pcsel", hz_if.PC_SEL, 2'd0);
      chk("bnt_vin", {hz_if.DE_V_IN, hz_if.EXE_V_IN}, 2'b00);
      next_cyc();
      #1;
      chk("bnt_ret_state", hz_if.CTRL_STATE, 2'd0);
      chk("bnt_cnt", hz_if.STALL_CNT, 3);

      // beq taken with one extra unresolved wait cycle.
      hz_if.DE_IR = BEQ;
      next_cyc();
      hz_if.DE_V = 1'b0; hz_if.EXE_IR = BEQ;
      #1;
      chk("bt_wait_state", hz_if.CTRL_STATE, 2'd1);
      chk("bt_wait_ld", ld, 5'b01111);
      chk("bt_wait_pcsel", hz_if.PC_SEL, 2'd0);
      next_cyc();
      hz_if.DE_V = 1'b0; hz_if.EXE_IR = BEQ;
      hz_if.EXE_BR_RESOLVED = 1'b1; hz_if.EXE_BR_TAKEN = 1'b1;
      #1;
      chk("bt_ld", ld, 5'b11111);
      chk("bt_pcsel", hz_if.PC_SEL, 2'd1);
      next_cyc();
      #1;
      chk("bt_ret_state", hz_if.CTRL_STATE, 2'd0);
      chk("bt_cnt", hz_if.STALL_CNT, 5);

      // Reset in BR_WAIT abandons the resolve.
      hz_if.DE_IR = BEQ;
      next_cyc();
      #1;
      chk("brst_pre_state", hz_if.CTRL_STATE, 2'd1);
      hz_if.DE_V = 1'b0; hz_if.EXE_IR = BEQ;
      hz_if.EXE_BR_RESOLVED = 1'b1; hz_if.EXE_BR_TAKEN = 1'b1;
      reset = 1'b1;
      #1;
      chk("brst_pcsel", hz_if.PC_SEL, 2'd0);
      chk("brst_ld", ld, 5'b00000);
      next_cyc();
      reset = 1'b0;
      #1;
      chk("brst_state", hz_if.CTRL_STATE, 2'd0);
      chk("brst_cnt", hz_if.STALL_CNT, 0);
      chk("brst_pcsel_after", hz_if.PC_SEL, 2'd0);

      // ECALL with no stalls: DRAIN, DRAIN, TRAP, RUN.
      next_cyc();
      hz_if.EXE_IR = ECALL; hz_if.EXE_ECALL = 1'b1;
      #1;
      chk("ec_ld", ld, 5'b01111);
      chk("ec_vin", {hz_if.DE_V_IN, hz_if.EXE_V_IN}, 2'b00);
      for (int i = 1; i <= 2; i++) begin
         next_cyc();
         hz_if.DE_V = 1'b0; hz_if.EXE_V = 1'b0;
         #1;
         chk($sformatf("ec_drain%0d_state", i), hz_if.CTRL_STATE, 2'd2);
         chk($sformatf("ec_drain%0d_trap", i), {hz_if.TRAP_CS, hz_if.PC_SEL}, 3'b000);
         chk($sformatf("ec_drain%0d_ld", i), ld, 5'b01111);
      end
      next_cyc();
      hz_if.DE_V = 1'b0; hz_if.EXE_V = 1'b0;
      #1;
      chk("ec_trap_state", hz_if.CTRL_STATE, 2'd3);
      chk("ec_trap_cs", hz_if.TRAP_CS, 1'b1);
      chk("ec_trap_pcsel", hz_if.PC_SEL, 2'd2);
      chk("ec_trap_ld", ld, 5'b11111);
      chk("ec_trap_vin", {hz_if.DE_V_IN, hz_if.EXE_V_IN}, 2'b00);
      next_cyc();
      #1;
      chk("ec_ret_state", hz_if.CTRL_STATE, 2'd0);
      chk("ec_ret_trap", hz_if.TRAP_CS, 1'b0);
      chk("ec_cnt", hz_if.STALL_CNT, 4);

      // ECALL with MEM_STALL over the first three drain cycles.
      next_cyc();
      do_reset();
      hz_if.EXE_IR = ECALL; hz_if.EXE_ECALL = 1'b1;
      #1;
      chk("ecs_ld", ld, 5'b01111);
      for (int i = 0; i < 3; i++) begin
         next_cyc();
         hz_if.DE_V = 1'b0; hz_if.EXE_V = 1'b0; hz_if.MEM_STALL = 1'b1;
         #1;
         chk($sformatf("ecs_frz%0d_ld", i), ld, 5'b00000);
         chk($sformatf("ecs_frz%0d_state", i), hz_if.CTRL_STATE, 2'd2);
         chk($sformatf("ecs_frz%0d_trap", i), {hz_if.TRAP_CS, hz_if.PC_SEL}, 3'b000);
      end
      for (int i = 0; i < 2; i++) begin
         next_cyc();
         hz_if.DE_V = 1'b0; hz_if.EXE_V = 1'b0;
         #1;
         chk($sformatf("ecs_drain%0d_state", i), hz_if.CTRL_STATE, 2'd2);
         chk($sformatf("ecs_drain%0d_trap", i), hz_if.TRAP_CS, 1'b0);
      end
      next_cyc();
      hz_if.DE_V = 1'b0; hz_if.EXE_V = 1'b0;
      #1;
      chk("ecs_trap_cs", hz_if.TRAP_CS, 1'b1);
      chk("ecs_trap_pcsel", hz_if.PC_SEL, 2'd2);
      next_cyc();
      #1;
      chk("ecs_ret_state", hz_if.CTRL_STATE, 2'd0);
      chk("ecs_cnt", hz_if.STALL_CNT, 7);

      // Counter at its maximum: one more stalled cycle wraps to zero.
      hz_if.MEM_STALL = 1'b1;
      #1;
      chk("wrap_ld", ld, 5'b00000);
      next_cyc();
      #1;
      chk("wrap_cnt", hz_if.STALL_CNT, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV64 pipeline (FETCH, DE, EXE/AGEX, MEM, WB). It observes the DE and EXE stage latches and the memory ready signals, and produces:
- per-stage load enables;
- bubble-insert valids;
- the next-PC select.

It owns four conditions: load-use interlock, branch/jump resolution wait, ECALL drain-and-redirect, and memory freeze. It replaces the ad-hoc `LD_AGEX`/`mem_stall` logic in decode.

## Interface
Parameters:
- `STALL_CNT_W`, default 32: width of the stall-cycle performance counter.

Ports:
- `CLK`  in  1  clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `DE_V`  in  1  valid bit of the DE latch.
- `DE_IR`  in  32  instruction in the DE latch.
- `EXE_V`  in  1  valid bit of the EXE latch.
- `EXE_IR`  in  32  instruction in the EXE latch.
- `EXE_DRID`  in  5  destination register of the EXE instruction.
- `EXE_BR_RESOLVED`  in  1  the EXE control-flow instruction has computed its outcome this cycle.
- `EXE_BR_TAKEN`  in  1  redirect required; qualified by `EXE_BR_RESOLVED`.
- `EXE_ECALL`  in  1  the EXE instruction is ECALL.
- `IF_STALL`  in  1  instruction memory not ready.
- `MEM_STALL`  in  1  data memory not ready.
- `LD_PC`, `LD_DE`, `LD_AGEX`, `LD_MEM`, `LD_WB`  out  1 each  stage latch enables.
- `DE_V_IN`  out  1  valid written into the DE latch when `LD_DE`=1.
- `EXE_V_IN`  out  1  valid written into the EXE latch when `LD_AGEX`=1; 0 inserts a bubble.
- `PC_SEL`  out  2  next-PC source: 0 = PC+4, 1 = branch/jump target, 2 = trap vector from the CSR file.
- `TRAP_CS`  out  1  one-cycle strobe that commits mepc/mcause in the CSR file.
- `CTRL_STATE`  out  2  current state, for debug.
- `STALL_CNT`  out  `STALL_CNT_W`  cycles with `LD_AGEX`=0 or `EXE_V_IN`=0 since reset; wraps modulo 2^`STALL_CNT_W`.

## Operation
States: `RUN`=0, `BR_WAIT`=1, `DRAIN`=2, `TRAP`=3. Register `drain_cnt`, 2 bits.

Decoded conditions:
- `is_cf`: `DE_V` and `DE_IR[6:0]` ∈ {1100011, 1101111, 1100111}.
- `uses_rs2`: `DE_IR[6:0]` ∈ {0110011, 0111011, 0100011, 1100011}.
- `load_use`: all of the following hold:
  - `EXE_V`;
  - `EXE_IR[6:0]`=0000011;
  - `EXE_DRID`≠0;
  - `DE_V`;
  - (`EXE_DRID`==`DE_IR[19:15]`) or (`uses_rs2` and `EXE_DRID`==`DE_IR[24:20]`).

Priority, highest first: reset > `MEM_STALL` > ECALL > state behaviour > `load_use` > `IF_STALL`.

`MEM_STALL`=1, in any state:
- All `LD_*`=0.
- State, `drain_cnt` and outputs `PC_SEL`/`TRAP_CS` are held at their non-acting values (`PC_SEL`=0, `TRAP_CS`=0).
- `STALL_CNT` increments.

`RUN`:
- Default: all `LD_*`=1, `DE_V_IN`=1, `EXE_V_IN`=`DE_V`, `PC_SEL`=0.
- `load_use`: `LD_PC`=`LD_DE`=0, `EXE_V_IN`=0. Stays in `RUN`.
- Otherwise, if `IF_STALL`: `LD_PC`=0, `DE_V_IN`=0; downstream stages advance normally.
- Otherwise, if `is_cf`: the instruction advances to EXE, `LD_PC`=0, `DE_V_IN`=0, next state `BR_WAIT`.

`BR_WAIT`:
- `LD_PC`=0, `DE_V_IN`=0, `EXE_V_IN`=0; MEM and WB advance.
- On `EXE_BR_RESOLVED`: `LD_PC`=1, `PC_SEL`=`EXE_BR_TAKEN` ? 1 : 0, next state `RUN`.
- JAL/JALR assert `EXE_BR_RESOLVED` with `EXE_BR_TAKEN`=1.

ECALL, when `EXE_V` and `EXE_ECALL` in `RUN` or `BR_WAIT`:
- `EXE_V_IN`=0, `DE_V_IN`=0, `LD_PC`=0.
- `drain_cnt`←2, next state `DRAIN`.

`DRAIN`:
- `LD_PC`=0, `DE_V_IN`=0, `EXE_V_IN`=0.
- `drain_cnt` decrements on each non-stalled cycle.
- When `drain_cnt`==1 and not `MEM_STALL`: next state `TRAP`. The ECALL is in WB on the following cycle.

`TRAP`, exactly one cycle:
- `TRAP_CS`=1, `PC_SEL`=2, `LD_PC`=1, `DE_V_IN`=0, `EXE_V_IN`=0.
- Next state `RUN`.

Reset:
- State←`RUN`, `drain_cnt`←0, `STALL_CNT`←0.
- While `reset`=1, all `LD_*`=0, `DE_V_IN`=0, `EXE_V_IN`=0, `PC_SEL`=0, `TRAP_CS`=0, `CTRL_STATE`=0.
- Reset mid-`DRAIN`/`BR_WAIT` abandons the sequence; no `TRAP_CS` is issued.

## Timing
- All outputs are combinational from the registered state and the current inputs. No output is registered except `CTRL_STATE`/`STALL_CNT`.
- Load-use costs exactly 1 bubble; at the next edge the load is in MEM and forwarding covers the dependency.
- Conditional branch minimum penalty: 1 cycle. Dispatch at edge N, resolve in the N+1 cycle, and the redirected fetch is latched at edge N+2.
- ECALL seen in EXE at cycle C with no stalls:
  - `DRAIN` during C+1 and C+2;
  - `TRAP` during C+3;
  - first trap-vector fetch latched at edge C+3→C+4.
- `MEM_STALL` arriving in the same cycle as `EXE_BR_RESOLVED` or the `TRAP` cycle defers that action. The FSM holds, and the action fires on the first cycle with `MEM_STALL`=0. `EXE_BR_RESOLVED` must remain asserted while EXE is frozen.

## Test plan
1. `ld x5,0(x1)` in EXE, `add x6,x5,x7` in DE → for one cycle `LD_PC`=`LD_DE`=0, `EXE_V_IN`=0; next cycle `EXE_V_IN`=1; `STALL_CNT`=1.
2. Load to x0 (`EXE_DRID`=0) followed by a dependent instruction → no stall; `STALL_CNT` stays 0.
3. `beq` in DE, not taken → `CTRL_STATE`=1 for one cycle, then resolves with `PC_SEL`=0, `LD_PC`=1. Taken → same sequence with `PC_SEL`=1.
4. ECALL enters EXE at cycle 10 → `CTRL_STATE`=2 at cycles 11–12, `TRAP_CS`=1 and `PC_SEL`=2 only at cycle 13, `CTRL_STATE`=0 at cycle 14.
5. Repeat scenario 4 with `MEM_STALL`=1 during cycles 11–13 → `TRAP_CS` fires at cycle 16; all `LD_*`=0 during the stall; `drain_cnt` is held.
6. `reset` asserted during `BR_WAIT` → the next cycle has `CTRL_STATE`=0, `STALL_CNT`=0, and no `PC_SEL`≠0 pulse. `STALL_CNT` preloaded to 2^32−1 then stalled once → reads 0.
